// File: rtl/mips_pkg.sv
// Shared MIPS constants, the fetch buffer entry layout and the J-type target helpers.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [5:0]  OP_J             = 6'b000010;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OP_J;
  endfunction

  // J targets keep the top nibble of the delay-slot address, not of the jump itself.
  function automatic logic [31:0] jump_target(input logic [31:0]        pc_plus4,
                                              input logic [INSTR_W-1:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched instructions; flush empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot the push needs, so full plus pop still accepts data.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding imem read, epoch-tagged redirects, decoupling buffer.
// Define FETCH_JPREDECODE_EN to let fetched J instructions steer the fetch PC directly.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc_plus4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      pc;
  logic [31:0]      req_addr;
  logic             outstanding;
  logic             epoch;
  logic             req_epoch;
  logic [CNT_W-1:0] fifo_count;
  logic             issue;
  logic             ack_valid;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [1:0]       unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // A new request only starts from idle, so the address never changes under a live request.
  assign issue     = !rst && !outstanding && !redirect_valid
                     && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign ack_valid = !rst && outstanding && imem_ack;
  assign push      = ack_valid && (req_epoch == epoch) && !redirect_valid;
  assign pop       = id_valid && id_ready && !redirect_valid;

  assign imem_req  = !rst && (outstanding || issue);
  assign imem_addr = outstanding ? req_addr : pc;

  assign push_entry.instr    = imem_rdata;
  assign push_entry.pc_plus4 = req_addr + 32'd4;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count)
  );

  assign id_valid    = (fifo_count != '0);
  assign id_instr    = head.instr;
  assign id_pc_plus4 = head.pc_plus4;

  // A redirect leaves any in-flight request on the bus; the epoch flip marks its data stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      req_addr    <= '0;
      outstanding <= 1'b0;
      epoch       <= 1'b0;
      req_epoch   <= 1'b0;
    end else begin
      if (ack_valid)
        outstanding <= 1'b0;
      if (redirect_valid) begin
        epoch <= ~epoch;
        pc    <= {redirect_pc[31:2], 2'b00};
      end else if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= pc;
        req_epoch   <= epoch;
        pc          <= pc + 32'd4;
      end
`ifdef FETCH_JPREDECODE_EN
      else if (push && is_jump(imem_rdata)) begin
        pc <= jump_target(req_addr + 32'd4, imem_rdata);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit, with a second instance for PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        id_valid2;
  logic        id_ready2;
  logic [31:0] id_instr2;
  logic [31:0] id_pc_plus4_2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;

  logic        gen_ack;
  logic        stray_ack;
  logic        mem_en;
  int          mem_lat;
  int          wait_cnt;
  logic        j_word_en;
  int          stab_err;

  logic        s_req, s_ack, s_rst, p_req, p_ack, p_rst;
  logic [31:0] s_addr, p_addr;
  logic        s2_req, s2_ack;
  logic [31:0] s2_addr;

  logic [31:0] ack_q[$];
  logic [31:0] del_pc_q[$];
  logic [31:0] del_instr_q[$];
  logic [31:0] addr2_q[$];
  logic [31:0] pc2_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_ack = gen_ack | stray_ack;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_ack       (imem_ack2),
    .imem_rdata     (imem_rdata2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .id_valid       (id_valid2),
    .id_ready       (id_ready2),
    .id_instr       (id_instr2),
    .id_pc_plus4    (id_pc_plus4_2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (j_word_en && a == 32'h0)
      return 32'h0800_0040;
    return {6'b101011, a[25:0]};
  endfunction

  // Memory model: answers mem_lat cycles after first seeing a request, and watches bus stability.
  always @(posedge clk) begin
    s_req  = imem_req;
    s_ack  = gen_ack;
    s_addr = imem_addr;
    s_rst  = rst;
    if (!s_rst && !p_rst && p_req && !p_ack && (!s_req || s_addr != p_addr))
      stab_err++;
    p_req  = s_req;
    p_ack  = imem_ack;
    p_addr = s_addr;
    p_rst  = s_rst;
    if (s_req && s_ack && !s_rst)
      ack_q.push_back(s_addr);
    #1;
    if (!mem_en || s_ack || !s_req || s_rst) begin
      gen_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= mem_lat) begin
      gen_ack    = 1'b1;
      imem_rdata = mem_word(s_addr);
      wait_cnt   = 0;
    end else begin
      wait_cnt++;
    end
  end

  always @(posedge clk) begin
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      del_pc_q.push_back(id_pc_plus4);
      del_instr_q.push_back(id_instr);
    end
  end

  always @(posedge clk) begin
    s2_req  = imem_req2;
    s2_ack  = imem_ack2;
    s2_addr = imem_addr2;
    if (!rst && s2_req && s2_ack)
      addr2_q.push_back(s2_addr);
    if (!rst && id_valid2)
      pc2_q.push_back(id_pc_plus4_2);
    #1;
    imem_ack2   = s2_req && !s2_ack && !rst;
    imem_rdata2 = mem_word(s2_addr);
  end

  task automatic clear_queues;
    ack_q.delete();
    del_pc_q.delete();
    del_instr_q.delete();
    addr2_q.delete();
    pc2_q.delete();
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    clear_queues();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 0", id_pc_plus4); end
    checks++; if (imem_req2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_wrap: got %b expected 0", imem_req2); end
    clear_queues();
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL first_req_wrap: got req=%b addr=%h expected req=1 addr=fffffff8", imem_req2, imem_addr2); end
  endtask

  task automatic test_sequential;
    repeat (30) @(negedge clk);
    checks++; if (ack_q.size() < 6 || del_pc_q.size() < 6) begin errors++; $display("[TB] FAIL seq_count: got acks=%0d delivered=%0d expected >=6 each", ack_q.size(), del_pc_q.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (ack_q[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, ack_q[i], 32'(4 * i)); end
        checks++; if (del_pc_q[i] !== 32'(4 * (i + 1)) || del_instr_q[i] !== mem_word(32'(4 * i))) begin
          errors++; $display("[TB] FAIL seq_deliver[%0d]: got pc4=%h instr=%h expected pc4=%h instr=%h", i, del_pc_q[i], del_instr_q[i], 32'(4 * (i + 1)), mem_word(32'(4 * i)));
        end
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL seq_stable: got %0d violations expected 0", stab_err); end
  endtask

  task automatic test_wrap;
    checks++; if (addr2_q.size() < 3 || pc2_q.size() < 3) begin errors++; $display("[TB] FAIL wrap_count: got acks=%0d delivered=%0d expected >=3 each", addr2_q.size(), pc2_q.size()); end
    else begin
      checks++; if (addr2_q[0] !== 32'hFFFF_FFF8 || addr2_q[1] !== 32'hFFFF_FFFC || addr2_q[2] !== 32'h0) begin
        errors++; $display("[TB] FAIL wrap_addr: got %h %h %h expected fffffff8 fffffffc 00000000", addr2_q[0], addr2_q[1], addr2_q[2]);
      end
      checks++; if (pc2_q[0] !== 32'hFFFF_FFFC || pc2_q[1] !== 32'h0 || pc2_q[2] !== 32'h4) begin
        errors++; $display("[TB] FAIL wrap_pc4: got %h %h %h expected fffffffc 00000000 00000004", pc2_q[0], pc2_q[1], pc2_q[2]);
      end
    end
  endtask

  task automatic test_backpressure;
    id_ready = 1'b0;
    mem_lat  = 0;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (id_valid) begin
        checks++; if (id_instr !== mem_word(32'h0) || id_pc_plus4 !== 32'h4) begin
          errors++; $display("[TB] FAIL bp_hold[%0d]: got instr=%h pc4=%h expected instr=%h pc4=00000004", i, id_instr, id_pc_plus4, mem_word(32'h0));
        end
      end
    end
    checks++; if (ack_q.size() != 2) begin errors++; $display("[TB] FAIL bp_fetches: got %0d expected 2", ack_q.size()); end
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall: got req=%b valid=%b expected req=0 valid=1", imem_req, id_valid); end
    id_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (del_pc_q.size() < 4) begin errors++; $display("[TB] FAIL bp_release_count: got %0d expected >=4", del_pc_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (del_pc_q[i] !== 32'(4 * (i + 1))) begin errors++; $display("[TB] FAIL bp_release[%0d]: got %h expected %h", i, del_pc_q[i], 32'(4 * (i + 1))); end
      end
    end
  endtask

  task automatic test_redirect_ack;
    bit found = 0;
    int d0, a0;
    id_ready = 1'b1;
    mem_lat  = 0;
    apply_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_ack && imem_addr == 32'h8) found = 1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL redir_ack_wait: got timeout expected ack at 00000008"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    d0 = del_pc_q.size();
    a0 = ack_q.size();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_ack_flush: got valid=%b expected 0", id_valid); end
    for (int i = 0; i < 30 && del_pc_q.size() <= d0; i++) @(negedge clk);
    checks++; if (del_pc_q.size() <= d0 || ack_q.size() <= a0) begin errors++; $display("[TB] FAIL redir_ack_timeout: got delivered=%0d expected >%0d", del_pc_q.size(), d0); end
    else begin
      checks++; if (ack_q[a0] !== 32'h100) begin errors++; $display("[TB] FAIL redir_ack_addr: got %h expected 00000100", ack_q[a0]); end
      checks++; if (del_pc_q[d0] !== 32'h104 || del_instr_q[d0] !== mem_word(32'h100)) begin
        errors++; $display("[TB] FAIL redir_ack_deliver: got pc4=%h instr=%h expected pc4=00000104 instr=%h", del_pc_q[d0], del_instr_q[d0], mem_word(32'h100));
      end
    end
  endtask

  task automatic test_redirect_stale;
    bit found = 0;
    int d0;
    id_ready = 1'b1;
    mem_lat  = 2;
    apply_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h4) found = 1;
    end
    @(negedge clk);
    checks++; if (!found || imem_req !== 1'b1 || imem_ack !== 1'b0) begin errors++; $display("[TB] FAIL stale_wait: got found=%0d req=%b ack=%b expected 1 1 0", found, imem_req, imem_ack); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    d0 = del_pc_q.size();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stale_hold: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr); end
    for (int i = 0; i < 40 && del_pc_q.size() <= d0; i++) @(negedge clk);
    checks++; if (del_pc_q.size() <= d0) begin errors++; $display("[TB] FAIL stale_timeout: got delivered=%0d expected >%0d", del_pc_q.size(), d0); end
    else begin
      checks++; if (del_pc_q[d0] !== 32'h204 || del_instr_q[d0] !== mem_word(32'h200)) begin
        errors++; $display("[TB] FAIL stale_deliver: got pc4=%h instr=%h expected pc4=00000204 instr=%h", del_pc_q[d0], del_instr_q[d0], mem_word(32'h200));
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL stale_stable: got %0d violations expected 0", stab_err); end
  endtask

  task automatic test_late_ack;
    id_ready = 1'b1;
    mem_lat  = 0;
    mem_en   = 1'b0;
    apply_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL late_rst_req: got %b expected 0", imem_req); end
    @(negedge clk);
    rst = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL late_ack_ignored: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000000", id_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_ack_novalid: got %b expected 0", id_valid); end
    mem_en = 1'b1;
    for (int i = 0; i < 20 && del_pc_q.size() == 0; i++) @(negedge clk);
    checks++; if (del_pc_q.size() == 0 || del_pc_q[0] !== 32'h4 || del_instr_q[0] !== mem_word(32'h0)) begin
      errors++; $display("[TB] FAIL late_ack_first: got count=%0d expected first pc4=00000004", del_pc_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pattern = 16'b1011_0010_1110_0110;
    mem_lat = 1;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      id_ready = pattern[i % 16];
      @(negedge clk);
    end
    id_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (del_pc_q.size() < 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected >=8", del_pc_q.size()); end
    for (int i = 0; i < del_pc_q.size(); i++) begin
      checks++; if (del_pc_q[i] !== 32'(4 * (i + 1)) || del_instr_q[i] !== mem_word(32'(4 * i))) begin
        errors++; $display("[TB] FAIL b2b_order[%0d]: got pc4=%h instr=%h expected pc4=%h", i, del_pc_q[i], del_instr_q[i], 32'(4 * (i + 1)));
      end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("[TB] FAIL b2b_stable: got %0d violations expected 0", stab_err); end
  endtask

  task automatic test_jump;
    logic [31:0] exp_next;
`ifdef FETCH_JPREDECODE_EN
    exp_next = 32'h0000_0100;
`else
    exp_next = 32'h0000_0004;
`endif
    j_word_en = 1'b1;
    id_ready  = 1'b1;
    mem_lat   = 0;
    apply_reset();
    for (int i = 0; i < 30 && (ack_q.size() < 2 || del_pc_q.size() < 1); i++) @(negedge clk);
    checks++; if (ack_q.size() < 2 || del_pc_q.size() < 1) begin errors++; $display("[TB] FAIL jump_timeout: got acks=%0d expected >=2", ack_q.size()); end
    else begin
      checks++; if (ack_q[1] !== exp_next) begin errors++; $display("[TB] FAIL jump_next_addr: got %h expected %h", ack_q[1], exp_next); end
      checks++; if (del_instr_q[0] !== 32'h0800_0040 || del_pc_q[0] !== 32'h4) begin
        errors++; $display("[TB] FAIL jump_deliver: got instr=%h pc4=%h expected instr=08000040 pc4=00000004", del_instr_q[0], del_pc_q[0]);
      end
    end
    j_word_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    redirect_valid2 = 1'b0; redirect_pc2 = '0; id_ready2 = 1'b1;
    gen_ack = 1'b0; stray_ack = 1'b0; mem_en = 1'b1; mem_lat = 0; wait_cnt = 0;
    j_word_en = 1'b0; stab_err = 0; imem_rdata = '0; imem_ack2 = 1'b0; imem_rdata2 = '0;
    p_req = 1'b0; p_ack = 1'b0; p_rst = 1'b1; p_addr = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_backpressure();
    test_redirect_ack();
    test_redirect_stale();
    test_late_ack();
    test_back_to_back();
    test_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1: clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port imem_req, output, 1: instruction memory read request.
REQ-006 SHALL have port imem_addr, output, 32: word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1: read data valid (one-cycle pulse).
REQ-008 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-009 SHALL have port redirect_valid, input, 1: branch/jump taken from downstream.
REQ-010 SHALL have port redirect_pc, input, 32: new fetch target.
REQ-011 SHALL have port id_valid, output, 1: instruction available to decode.
REQ-012 SHALL have port id_ready, input, 1: decode accepts the instruction.
REQ-013 SHALL have port id_instr, output, 32: instruction to decode.
REQ-014 SHALL have port id_pc_plus4, output, 32: address of id_instr plus 4.

Function
REQ-015 SHALL allow at most one outstanding memory request; imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ack is sampled high.
REQ-016 SHALL issue a request only when buffered entries plus outstanding requests < FIFO_DEPTH.
REQ-017 SHALL advance fetch PC by 4 (mod 2^32) per issued request; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-018 SHALL drive imem_addr[1:0] = 2'b00 and ignore redirect_pc[1:0].
REQ-019 SHALL push {imem_rdata, addr+4} into the buffer on the cycle imem_ack is high; the entry is visible on id_* the next cycle.
REQ-020 SHALL pop the head entry on id_valid && id_ready; a push and a pop in the same cycle SHALL both occur, including when the buffer is full.
REQ-021 SHALL hold id_instr and id_pc_plus4 stable while id_valid && !id_ready.
REQ-022 SHALL, on redirect_valid, flush the buffer, drop id_valid the next cycle, and load fetch PC with redirect_pc; the first new request SHALL issue no earlier than the next cycle.
REQ-023 SHALL discard the response to any request outstanding at redirect (epoch tag), including an ack coincident with redirect_valid.
REQ-024 SHALL give redirect_valid priority over id_ready, imem_ack and request issue in the same cycle.
REQ-025 SHALL ignore imem_ack when no request is tracked.
REQ-026 SHALL never drop or duplicate an instruction absent a redirect; decode order equals fetch order.

Reset
REQ-027 SHALL, while rst is high, set fetch PC = RESET_PC, buffer empty, no outstanding request, epoch = 0, imem_req = 0, id_valid = 0, id_instr = 0, id_pc_plus4 = 0.
REQ-028 SHALL treat rst asserted mid-transaction as abandoning it; a late imem_ack after reset SHALL be ignored per REQ-025.
REQ-029 SHALL issue the first request on the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with FETCH_JPREDECODE_EN defined, predecode each acked word: opcode 6'b000010 (J) SHALL be pushed normally and fetch SHALL redirect internally to {addr+4[31:28], instr[25:0], 2'b00} without flushing the buffer.
REQ-031 SHALL, without FETCH_JPREDECODE_EN, fetch sequentially past J; the control flow change comes only from redirect_valid.

Structure
REQ-032 SHALL take OP_J, instruction width and the default reset PC from shared package mips_pkg.
REQ-033 SHALL place the buffer in sub-module fetch_fifo (sync FIFO with push/pop/flush, count output).

Verification
REQ-034 SHALL cover reset then imem_ack 1 cycle after each req, id_ready=1: imem_addr 0,4,8,...; id_pc_plus4 4,8,12,... in order.
REQ-035 SHALL cover id_ready=0 for 10 cycles: imem_req stops after 2 buffered words; id_instr is held; no loss on release.
REQ-036 SHALL cover redirect_valid, redirect_pc=32'h0000_0100, coincident with an ack: acked word is not delivered; next imem_addr = 0x100.
REQ-037 SHALL cover RESET_PC=32'hFFFF_FFF8, run 3 fetches: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 SHALL cover, with FETCH_JPREDECODE_EN, word 32'h0800_0040 at addr 0: J delivered, next fetch addr 0x100; without the macro, next fetch addr 4.
